// File: rtl/wbu_stage.sv
// Writeback stage: captures one retiring instruction, waits for late load
// data if needed, extracts/extends load bytes, and commits GPR/CSR writes
// with a single-cycle retire pulse and an instret counter.
module wbu_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       exu_res,
  input  logic [XLEN-1:0]       csr_res,
  input  logic                  csr_res_en,
  input  logic                  load_en,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [2:0]            load_off,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_wen,
  input  logic                  lsu_rvalid,
  input  logic [XLEN-1:0]       lsu_rdata,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wr_en_csr,
  output logic [XLEN-1:0]       data_wr_csr,
  output logic                  retire_valid,
  output logic [XLEN-1:0]       retire_pc,
  output logic [CNT_W-1:0]      instret
);

  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} state_t;

  // Shift the raw word down to the addressed byte, then size and extend it.
  // Misaligned offsets are not trapped; whatever bits land low are used.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] data,
                                              input logic [1:0]      size,
                                              input logic            uns,
                                              input logic [2:0]      off);
    logic [OFF_W-1:0]   o;
    logic [XLEN-1:0]    sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [XLEN-1:0]    r;
    o  = off[OFF_W-1:0];
    sh = data >> {o, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (size)
      2'd0:    r = uns ? XLEN'(sh[7:0])  : XLEN'(b);
      2'd1:    r = uns ? XLEN'(sh[15:0]) : XLEN'(h);
      2'd3:    r = (XLEN == 64) ? sh : (uns ? XLEN'(sh[31:0]) : XLEN'(w));
      default: r = uns ? XLEN'(sh[31:0]) : XLEN'(w);
    endcase
    return r;
  endfunction

  state_t                  state_q;
  logic [XLEN-1:0]         pc_q, csr_q;
  logic                    csr_en_q, rd_wen_q, uns_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [1:0]              size_q;
  logic [2:0]              off_q;

  logic                    retire_valid_q, rf_wen_q, wr_en_csr_q;
  logic [XLEN-1:0]         retire_pc_q, rf_wdata_q, data_wr_csr_q;
  logic [REG_ADDR_W-1:0]   rf_waddr_q;
  logic [CNT_W-1:0]        instret_q;

  logic                    accept;
  logic                    commit_d;
  logic [XLEN-1:0]         pc_d, res_d, csr_d;
  logic [REG_ADDR_W-1:0]   rd_d;
  logic                    rd_wen_d, csr_en_d;

  assign in_ready = (state_q != WAIT_LOAD);
  assign accept   = in_valid && in_ready;

  // Select the payload that commits on the next edge, either straight from
  // the inputs (direct commit) or from the capture registers (late load).
  always_comb begin
    commit_d = 1'b0;
    pc_d     = pc_q;
    res_d    = '0;
    csr_d    = csr_q;
    csr_en_d = csr_en_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    if (state_q == WAIT_LOAD) begin
      if (lsu_rvalid) begin
        commit_d = 1'b1;
        res_d    = extract(lsu_rdata, size_q, uns_q, off_q);
      end
    end else if (accept) begin
      pc_d     = in_pc;
      csr_d    = csr_res;
      csr_en_d = csr_res_en;
      rd_d     = rd_addr;
      rd_wen_d = rd_wen;
      if (!load_en) begin
        commit_d = 1'b1;
        res_d    = exu_res;
      end else if (lsu_rvalid) begin
        commit_d = 1'b1;
        res_d    = extract(lsu_rdata, load_size, load_unsigned, load_off);
      end
    end
  end

  // FSM, capture registers, registered commit outputs and instret.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      retire_valid_q <= 1'b0;
      rf_wen_q       <= 1'b0;
      wr_en_csr_q    <= 1'b0;
      retire_pc_q    <= '0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      data_wr_csr_q  <= '0;
      instret_q      <= '0;
    end else begin
      if (accept) begin
        pc_q     <= in_pc;
        csr_q    <= csr_res;
        csr_en_q <= csr_res_en;
        rd_q     <= rd_addr;
        rd_wen_q <= rd_wen;
        size_q   <= load_size;
        uns_q    <= load_unsigned;
        off_q    <= load_off;
      end
      if (commit_d)
        state_q <= COMMIT;
      else if ((accept && load_en) || (state_q == WAIT_LOAD))
        state_q <= WAIT_LOAD;
      else
        state_q <= IDLE;
      retire_valid_q <= commit_d;
      rf_wen_q       <= commit_d && rd_wen_d && (rd_d != '0);
      wr_en_csr_q    <= commit_d && csr_en_d;
      if (commit_d) begin
        retire_pc_q   <= pc_d;
        rf_waddr_q    <= rd_d;
        rf_wdata_q    <= res_d;
        data_wr_csr_q <= csr_d;
      end
      if (retire_valid_q)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;
  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign wr_en_csr    = wr_en_csr_q;
  assign data_wr_csr  = data_wr_csr_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wbu_stage.sv
// Bench for wbu_stage: table-driven single-cycle commits, hand sequences for
// late loads, reset during a pending load and instret wrap (CNT_W=4).
module tb_wbu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, exu_res = '0, csr_res = '0;
  logic        csr_res_en = 1'b0, load_en = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  load_size = '0;
  logic [2:0]  load_off = '0;
  logic [4:0]  rd_addr = '0;
  logic        rd_wen = 1'b0;
  logic        lsu_rvalid = 1'b0;
  logic [31:0] lsu_rdata = '0;
  logic        rf_wen, wr_en_csr, retire_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, data_wr_csr, retire_pc;
  logic [3:0]  instret;

  wbu_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .exu_res(exu_res), .csr_res(csr_res), .csr_res_en(csr_res_en),
    .load_en(load_en), .load_size(load_size), .load_unsigned(load_unsigned),
    .load_off(load_off), .rd_addr(rd_addr), .rd_wen(rd_wen),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wr_en_csr(wr_en_csr), .data_wr_csr(data_wr_csr),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, exu, csr;
    logic        csr_en, ld;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [4:0]  rd;
    logic        wen, rv;
    logic [31:0] rdata, exp_wdata;
    logic        exp_rf_wen;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        rf_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_en;
    logic [31:0] csr;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, exu, csr, input logic csr_en, ld,
                              input logic [1:0] size, input logic uns, input logic [2:0] off,
                              input logic [4:0] rd, input logic wen, rv,
                              input logic [31:0] rdata, exp_wdata, input logic exp_rf_wen);
    vec_t v;
    v.pc = pc; v.exu = exu; v.csr = csr; v.csr_en = csr_en; v.ld = ld;
    v.size = size; v.uns = uns; v.off = off; v.rd = rd; v.wen = wen; v.rv = rv;
    v.rdata = rdata; v.exp_wdata = exp_wdata; v.exp_rf_wen = exp_rf_wen;
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction for one cycle and queue its expected commit.
  task automatic send(input vec_t v);
    exp_t e;
    chk("in_ready_at_send", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_pc = v.pc; exu_res = v.exu; csr_res = v.csr;
    csr_res_en = v.csr_en; load_en = v.ld; load_size = v.size;
    load_unsigned = v.uns; load_off = v.off; rd_addr = v.rd; rd_wen = v.wen;
    lsu_rvalid = v.rv; lsu_rdata = v.rdata;
    e.cyc    = (!v.ld || v.rv) ? cyc + 1 : 0;
    e.pc     = v.pc;
    e.rf_wen = v.exp_rf_wen;
    e.waddr  = v.rd;
    e.wdata  = v.exp_wdata;
    e.csr_en = v.csr_en;
    e.csr    = v.csr;
    sb.push_back(e);
    idle(1);
    in_valid = 1'b0;
    lsu_rvalid = 1'b0;
  endtask

  // Scoreboard monitor: every retire must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (retire_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire_pc", 64'(retire_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_cycle", 64'(cyc), 64'(e.cyc));
          chk("retire_pc", 64'(retire_pc), 64'(e.pc));
          chk("rf_wen", 64'(rf_wen), 64'(e.rf_wen));
          chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
          chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
          chk("wr_en_csr", 64'(wr_en_csr), 64'(e.csr_en));
          if (e.csr_en) chk("data_wr_csr", 64'(data_wr_csr), 64'(e.csr));
        end
      end else begin
        chk("strobes_idle", 64'({rf_wen, wr_en_csr}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(32'h100, 32'h11, 32'h0,    0, 0, 2'd0, 0, 3'd0, 5'd1,  1, 0, 32'h0,         32'h11,        1);
    tbl[1]  = mk(32'h104, 32'h22, 32'h0,    0, 0, 2'd0, 0, 3'd0, 5'd2,  1, 0, 32'h0,         32'h22,        1);
    tbl[2]  = mk(32'h108, 32'h33, 32'h0,    0, 0, 2'd0, 0, 3'd0, 5'd3,  1, 0, 32'h0,         32'h33,        1);
    tbl[3]  = mk(32'h10C, 32'h0,  32'h0,    0, 1, 2'd1, 1, 3'd2, 5'd8,  1, 1, 32'hBEEF_0000, 32'h0000_BEEF, 1);
    tbl[4]  = mk(32'h110, 32'h0,  32'h0,    0, 1, 2'd0, 0, 3'd0, 5'd9,  1, 1, 32'h1234_5680, 32'hFFFF_FF80, 1);
    tbl[5]  = mk(32'h114, 32'h0,  32'h0,    0, 1, 2'd1, 0, 3'd0, 5'd10, 1, 1, 32'h0000_8001, 32'hFFFF_8001, 1);
    tbl[6]  = mk(32'h118, 32'h0,  32'h0,    0, 1, 2'd2, 0, 3'd0, 5'd11, 1, 1, 32'h8765_4321, 32'h8765_4321, 1);
    tbl[7]  = mk(32'h11C, 32'h0,  32'h0,    0, 1, 2'd3, 1, 3'd0, 5'd12, 1, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    tbl[8]  = mk(32'h120, 32'h0,  32'h0,    0, 1, 2'd0, 1, 3'd3, 5'd13, 1, 1, 32'hA500_0000, 32'h0000_00A5, 1);
    tbl[9]  = mk(32'h124, 32'h0,  32'h0,    0, 1, 2'd1, 0, 3'd3, 5'd14, 1, 1, 32'hFF00_0000, 32'h0000_00FF, 1);
    tbl[10] = mk(32'h128, 32'h55, 32'h1800, 1, 0, 2'd0, 0, 3'd0, 5'd0,  1, 0, 32'h0,         32'h55,        0);
    tbl[11] = mk(32'h12C, 32'h77, 32'h0,    0, 0, 2'd0, 0, 3'd0, 5'd7,  0, 0, 32'h0,         32'h77,        0);
    tbl[12] = mk(32'h130, 32'h99, 32'hABCD, 1, 0, 2'd0, 0, 3'd0, 5'd4,  1, 0, 32'h0,         32'h99,        1);

    // Reset state
    idle(2);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_strobes", 64'({retire_valid, rf_wen, wr_en_csr}), 64'd0);
    chk("rst_data", 64'({rf_waddr, rf_wdata, data_wr_csr, retire_pc} != '0), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    rst = 1'b0;
    idle(1);

    // Back-to-back ALU instructions
    for (int i = 0; i < 3; i++) send(tbl[i]);
    idle(2);
    chk("instret_after_alu", 64'(instret), 64'd3);
    chk("rf_wdata_hold", 64'(rf_wdata), 64'h33);
    chk("rf_waddr_hold", 64'(rf_waddr), 64'd3);

    // Same-cycle loads, x0 write, CSR write, dual strobe
    for (int i = 3; i < 13; i++) send(tbl[i]);
    idle(2);

    // Stray load data while idle must be ignored
    lsu_rvalid = 1'b1; lsu_rdata = 32'hDEAD_BEEF;
    idle(1);
    lsu_rvalid = 1'b0;
    idle(1);

    // Delayed load: data arrives three cycles after acceptance
    send(mk(32'h200, 32'h0, 32'h0, 0, 1, 2'd0, 0, 3'd1, 5'd5, 1, 0, 32'h0, 32'hFFFF_FF80, 1));
    for (int i = 0; i < 2; i++) begin
      chk("in_ready_waiting", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_pc = 32'hBAD0; exu_res = 32'hBAD1; load_en = 1'b0;
      idle(1);
    end
    in_valid = 1'b0;
    chk("in_ready_waiting", 64'(in_ready), 64'd0);
    lsu_rvalid = 1'b1; lsu_rdata = 32'h0000_8000;
    sb[sb.size()-1].cyc = cyc + 1;
    idle(1);
    lsu_rvalid = 1'b0;
    chk("in_ready_commit", 64'(in_ready), 64'd1);
    idle(2);

    // Reset while waiting for load data discards the instruction
    send(mk(32'h300, 32'h0, 32'h0, 0, 1, 2'd2, 0, 3'd0, 5'd6, 1, 0, 32'h0, 32'h1234, 1));
    idle(1);
    rst = 1'b1;
    sb.delete();
    idle(1);
    rst = 1'b0;
    lsu_rvalid = 1'b1; lsu_rdata = 32'h0000_1234;
    idle(1);
    lsu_rvalid = 1'b0;
    idle(2);
    chk("rst_mid_instret", 64'(instret), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);

    // instret wrap with a 4-bit counter
    for (int i = 0; i < 17; i++)
      send(mk(32'h400 + 32'(i * 4), 32'(i), 32'h0, 0, 0, 2'd0, 0, 3'd0, 5'(i % 31 + 1), 1, 0,
              32'h0, 32'(i), 1));
    idle(2);
    chk("instret_wrap", 64'(instret), 64'd1);

    // Drain, bounded
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
